mem_mr_xfer_req_dispatcher: RTL and testbench

Request-side counterpart of the memory transfer acknowledge path in MEM_XFER_INTF. Takes a single transfer request from AXI4 slave control and routes it to one of two engines. Writes and new reads go to the XMIT engine. Address-contiguous reads go to RCV_CNTRL as a continuation of an open continuous read. The block also tracks the open continuous-read window, and closes it on timeout, on a non-contiguous request or on a write.

---
 rtl/mem_xfer_pkg.sv | 15 +
 rtl/mem_cont_rd_tracker.sv | 54 +++++
 rtl/mem_mr_xfer_req_dispatcher.sv | 141 ++++++++++++++
 tb/tb_mem_mr_xfer_req_dispatcher.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_xfer_pkg.sv
// Shared definitions for the memory transfer request/acknowledge path:
// dispatcher state encoding and the write/read direction constants.
package mem_xfer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_XMIT_REQ = 2'd1;
    localparam state_t ST_CONT_REQ = 2'd2;
    localparam state_t ST_TERM     = 2'd3;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

endpackage

// File: rtl/mem_cont_rd_tracker.sv
// Continuous-read window bookkeeping: the expected next address, the
// end-of-transfer carry (address wrap) and the idle timeout counter.
module mem_cont_rd_tracker #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8,
    parameter int TMO_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_next,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [LEN_W-1:0]  cap_btcnt,
    input  logic [ADDR_W-1:0] cmp_addr,
    input  logic              tmo_run,
    input  logic              tmo_clr,
    input  logic [TMO_W-1:0]  tmo_limit,
    output logic              addr_match,
    output logic              tmo_expire,
    output logic              wrap
);

    logic [ADDR_W-1:0] next_addr_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic [LEN_W:0]    len_ext;
    logic [ADDR_W:0]   end_sum;

    // A zero byte count stands for the full 2^LEN_W bytes.
    assign len_ext    = (cap_btcnt == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cap_btcnt};
    assign end_sum    = {1'b0, cap_addr} + {{(ADDR_W - LEN_W){1'b0}}, len_ext};
    assign wrap       = end_sum[ADDR_W];
    assign addr_match = (cmp_addr == next_addr_reg);
    assign tmo_expire = (tmo_cnt_reg == tmo_limit);

    // Remember where the open window would continue after an accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_addr_reg <= '0;
        end else if (load_next) begin
            next_addr_reg <= end_sum[ADDR_W-1:0];
        end
    end

    // Idle timer: cleared outside IDLE, counts idle cycles, saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_reg <= '0;
        end else if (tmo_clr) begin
            tmo_cnt_reg <= '0;
        end else if (tmo_run && (tmo_cnt_reg != '1)) begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
        end
    end

endmodule

// File: rtl/mem_mr_xfer_req_dispatcher.sv
// Routes one AXI-side transfer request to the XMIT engine or, for an
// address-contiguous read inside an open window, to RCV_CNTRL; closes the
// window on write, non-contiguous read, disable or idle timeout.
module mem_mr_xfer_req_dispatcher
    import mem_xfer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8,
    parameter int TMO_W  = 16
) (
    input  logic              mem_clk,
    input  logic              mem_rst,
    input  logic              mem_mr_xfer_valid,
    input  logic              mem_mr_xfer_wr_rd,
    input  logic [ADDR_W-1:0] mem_mr_xfer_addr,
    input  logic [LEN_W-1:0]  mem_mr_xfer_btcnt,
    input  logic              cont_rd_en,
    input  logic [TMO_W-1:0]  cont_rd_tmo,
    output logic              xmittr_req,
    input  logic              xmittr_ack,
    output logic              cont_rd_req,
    input  logic              cont_rd_ack,
    output logic              cont_wr_rd_req,
    output logic              cont_rd_term,
    input  logic              cont_rd_term_ack,
    output logic              cont_rd_active
);

    state_t            state_reg, state_next;
    logic              active_reg, active_next;
    logic              wr_rd_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  btcnt_reg;
    logic              capture, load_next;
    logic              addr_match, tmo_expire, wrap;
    logic              tmo_run, tmo_clr;

    assign tmo_clr        = (state_reg != ST_IDLE);
    assign tmo_run        = (state_reg == ST_IDLE) && active_reg && !mem_mr_xfer_valid;
    assign cont_rd_active = active_reg;

    mem_cont_rd_tracker #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .TMO_W  (TMO_W)
    ) u_tracker (
        .clk        (mem_clk),
        .rst        (mem_rst),
        .load_next  (load_next),
        .cap_addr   (addr_reg),
        .cap_btcnt  (btcnt_reg),
        .cmp_addr   (mem_mr_xfer_addr),
        .tmo_run    (tmo_run),
        .tmo_clr    (tmo_clr),
        .tmo_limit  (cont_rd_tmo),
        .addr_match (addr_match),
        .tmo_expire (tmo_expire),
        .wrap       (wrap)
    );

    // Next-state, window and capture decisions; acks outside their state are ignored.
    always_comb begin
        state_next  = state_reg;
        active_next = active_reg;
        capture     = 1'b0;
        load_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (mem_mr_xfer_valid) begin
                    capture = 1'b1;
                    if (!active_reg) begin
                        state_next = ST_XMIT_REQ;
                    end else if ((mem_mr_xfer_wr_rd == RD) && cont_rd_en && addr_match) begin
                        state_next = ST_CONT_REQ;
                    end else begin
                        state_next = ST_TERM;
                    end
                end else if (active_reg && (tmo_expire || !cont_rd_en)) begin
                    state_next = ST_TERM;
                end
            end
            ST_XMIT_REQ: begin
                if (xmittr_ack) begin
                    state_next = ST_IDLE;
                    if ((wr_rd_reg == RD) && cont_rd_en) begin
                        load_next   = 1'b1;
                        active_next = !wrap;
                    end
                end
            end
            ST_CONT_REQ: begin
                if (cont_rd_ack) begin
                    state_next = ST_IDLE;
                    load_next  = 1'b1;
                    if (wrap) begin
                        active_next = 1'b0;
                    end
                end
            end
            default: begin
                if (cont_rd_term_ack) begin
                    state_next  = ST_IDLE;
                    active_next = 1'b0;
                end
            end
        endcase
    end

    // State, window flag and registered outputs decoded from the next state.
    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            state_reg      <= ST_IDLE;
            active_reg     <= 1'b0;
            xmittr_req     <= 1'b0;
            cont_rd_req    <= 1'b0;
            cont_wr_rd_req <= 1'b0;
            cont_rd_term   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            active_reg     <= active_next;
            xmittr_req     <= (state_next == ST_XMIT_REQ);
            cont_rd_req    <= (state_next == ST_CONT_REQ);
            cont_wr_rd_req <= (state_next == ST_CONT_REQ);
            cont_rd_term   <= (state_next == ST_TERM);
        end
    end

    // Hold the request fields that the engines and the end-address sum work from.
    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            wr_rd_reg <= 1'b0;
            addr_reg  <= '0;
            btcnt_reg <= '0;
        end else if (capture) begin
            wr_rd_reg <= mem_mr_xfer_wr_rd;
            addr_reg  <= mem_mr_xfer_addr;
            btcnt_reg <= mem_mr_xfer_btcnt;
        end
    end

endmodule

// File: tb/tb_mem_mr_xfer_req_dispatcher.sv
// Directed bench for the transfer request dispatcher: a table of requests
// with expected routing and window state, plus hand sequences for timeout,
// expiry-cycle race, disable, zero timeout and asynchronous reset.
module tb_mem_mr_xfer_req_dispatcher;

    localparam int R_XMIT = 0;
    localparam int R_CONT = 1;
    localparam int R_TERM = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        wr_rd = 1'b0;
    logic [31:0] addr = '0;
    logic [7:0]  btcnt = '0;
    logic        cont_rd_en = 1'b1;
    logic [15:0] cont_rd_tmo = 16'd20;
    logic        xmittr_req, cont_rd_req, cont_wr_rd_req, cont_rd_term, cont_rd_active;
    logic        xmittr_ack = 1'b0;
    logic        cont_rd_ack = 1'b0;
    logic        cont_rd_term_ack = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        wr_rd;
        logic [31:0] addr;
        logic [7:0]  btcnt;
        int          route;
        logic        exp_active;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    mem_mr_xfer_req_dispatcher dut (
        .mem_clk           (clk),
        .mem_rst           (rst),
        .mem_mr_xfer_valid (valid),
        .mem_mr_xfer_wr_rd (wr_rd),
        .mem_mr_xfer_addr  (addr),
        .mem_mr_xfer_btcnt (btcnt),
        .cont_rd_en        (cont_rd_en),
        .cont_rd_tmo       (cont_rd_tmo),
        .xmittr_req        (xmittr_req),
        .xmittr_ack        (xmittr_ack),
        .cont_rd_req       (cont_rd_req),
        .cont_rd_ack       (cont_rd_ack),
        .cont_wr_rd_req    (cont_wr_rd_req),
        .cont_rd_term      (cont_rd_term),
        .cont_rd_term_ack  (cont_rd_term_ack),
        .cont_rd_active    (cont_rd_active)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_xreq"}, {31'd0, xmittr_req}, 32'd0);
        chk({name, "_creq"}, {31'd0, cont_rd_req}, 32'd0);
        chk({name, "_route"}, {31'd0, cont_wr_rd_req}, 32'd0);
        chk({name, "_term"}, {31'd0, cont_rd_term}, 32'd0);
        chk({name, "_active"}, {31'd0, cont_rd_active}, 32'd0);
    endtask

    // Acknowledge an open close request and confirm the window is shut.
    task automatic close_term(input string name);
        cont_rd_term_ack = 1'b1;
        step();
        cont_rd_term_ack = 1'b0;
        chk({name, "_term_low"}, {31'd0, cont_rd_term}, 32'd0);
        chk({name, "_closed"}, {31'd0, cont_rd_active}, 32'd0);
    endtask

    // Count cycles from now until cont_rd_term is seen high (bounded).
    task automatic count_to_term(output int n);
        n = 0;
        while (!cont_rd_term && n < 60) begin
            step();
            n++;
        end
    endtask

    // One full request: present it, check routing, acknowledge, check window.
    task automatic do_req(input string name, input logic w, input logic [31:0] a,
                          input logic [7:0] b, input int route, input logic exp_act);
        valid = 1'b1;
        wr_rd = w;
        addr  = a;
        btcnt = b;
        step();
        if (route == R_TERM) begin
            chk({name, "_term"}, {31'd0, cont_rd_term}, 32'd1);
            chk({name, "_no_xreq"}, {31'd0, xmittr_req}, 32'd0);
            step();
            chk({name, "_term_hold"}, {31'd0, cont_rd_term}, 32'd1);
            close_term(name);
            chk({name, "_xreq_wait"}, {31'd0, xmittr_req}, 32'd0);
            step();
        end
        if (route == R_CONT) begin
            chk({name, "_creq"}, {31'd0, cont_rd_req}, 32'd1);
            chk({name, "_route"}, {31'd0, cont_wr_rd_req}, 32'd1);
            chk({name, "_no_xreq"}, {31'd0, xmittr_req}, 32'd0);
            chk({name, "_no_term"}, {31'd0, cont_rd_term}, 32'd0);
            step();
            chk({name, "_creq_hold"}, {31'd0, cont_rd_req}, 32'd1);
            cont_rd_ack = 1'b1;
            step();
            cont_rd_ack = 1'b0;
            valid = 1'b0;
            chk({name, "_creq_low"}, {31'd0, cont_rd_req}, 32'd0);
            chk({name, "_route_low"}, {31'd0, cont_wr_rd_req}, 32'd0);
        end else begin
            chk({name, "_xreq"}, {31'd0, xmittr_req}, 32'd1);
            chk({name, "_no_creq"}, {31'd0, cont_rd_req}, 32'd0);
            chk({name, "_no_term2"}, {31'd0, cont_rd_term}, 32'd0);
            step();
            chk({name, "_xreq_hold"}, {31'd0, xmittr_req}, 32'd1);
            xmittr_ack = 1'b1;
            step();
            xmittr_ack = 1'b0;
            valid = 1'b0;
            chk({name, "_xreq_low"}, {31'd0, xmittr_req}, 32'd0);
        end
        chk({name, "_active"}, {31'd0, cont_rd_active}, {31'd0, exp_act});
        $display("[TB] txn %s wr=%0d addr=%08h bt=%0d route=%0d active=%0d",
                 name, w, a, b, route, cont_rd_active);
    endtask

    initial begin
        #100_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        vecs[0]  = '{1'b1, 32'h0000_0100, 8'd16, R_XMIT, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0200, 8'd32, R_XMIT, 1'b1};
        vecs[2]  = '{1'b0, 32'h0000_0220, 8'd32, R_CONT, 1'b1};
        vecs[3]  = '{1'b0, 32'h0000_0240, 8'd16, R_CONT, 1'b1};
        vecs[4]  = '{1'b0, 32'h0000_0300, 8'd8,  R_TERM, 1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0308, 8'd4,  R_TERM, 1'b0};
        vecs[6]  = '{1'b0, 32'hFFFF_FFF0, 8'd16, R_XMIT, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 8'd0,  R_XMIT, 1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0100, 8'd0,  R_CONT, 1'b1};
        vecs[9]  = '{1'b0, 32'hFFFF_FF00, 8'd0,  R_TERM, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0000, 8'd16, R_XMIT, 1'b1};
        vecs[11] = '{1'b0, 32'h0000_0010, 8'd16, R_CONT, 1'b1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk_all_zero("post_reset");

        // Table of requests with expected routing and window state.
        for (int i = 0; i < 12; i++) begin
            repeat (3) step();
            do_req($sformatf("vec%0d", i), vecs[i].wr_rd, vecs[i].addr, vecs[i].btcnt,
                   vecs[i].route, vecs[i].exp_active);
        end

        // Idle timeout: window left open by the last vector, tmo = 20.
        count_to_term(n);
        chk("tmo20_latency", n, 32'd21);
        close_term("tmo20");

        // Request in the expiry cycle wins and continues the window.
        do_req("race_open", 1'b0, 32'h0000_0500, 8'd16, R_XMIT, 1'b1);
        repeat (20) step();
        do_req("race_cont", 1'b0, 32'h0000_0510, 8'd16, R_CONT, 1'b1);

        // Disabling continuous read closes the open window.
        cont_rd_en = 1'b0;
        step();
        chk("disable_term", {31'd0, cont_rd_term}, 32'd1);
        close_term("disable");
        cont_rd_en = 1'b1;

        // Zero timeout closes right after each read.
        cont_rd_tmo = 16'd0;
        do_req("tmo0_open", 1'b0, 32'h0000_0600, 8'd16, R_XMIT, 1'b1);
        count_to_term(n);
        chk("tmo0_latency", n, 32'd1);
        close_term("tmo0");
        cont_rd_tmo = 16'd20;

        // Asynchronous reset during a continuation request.
        do_req("rst_open", 1'b0, 32'h0000_0700, 8'd16, R_XMIT, 1'b1);
        valid = 1'b1;
        wr_rd = 1'b0;
        addr  = 32'h0000_0710;
        btcnt = 8'd16;
        step();
        chk("rst_creq", {31'd0, cont_rd_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        valid = 1'b0;
        step();
        rst = 1'b0;
        cont_rd_ack = 1'b1;
        step();
        cont_rd_ack = 1'b0;
        chk_all_zero("late_ack");
        step();
        chk_all_zero("late_ack2");
        do_req("rst_after", 1'b0, 32'h0000_0710, 8'd16, R_XMIT, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
